pc_gen: RTL and testbench

Parametrised program-counter generator for the fetch stage; successor to the single-mode PC register.
- Holds the PC and selects the next PC from five sources: sequential, PC-relative branch, absolute jump, register jump, and exception/return.
- Adds stall, exception entry with EPC capture, ERET return and misaligned-target detection.
- Feeds the instruction memory address and the link-value path of the datapath.

---
 rtl/pc_gen.sv | 156 +++++++++++++++
 tb/tb_pc_gen.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// Fetch-stage program counter: five next-PC sources, stall, exception entry/return, misaligned JR trap.
// Optional return-address stack is built when PC_GEN_RAS_EN is defined.
module pc_gen #(
    parameter int          WIDTH     = 32,
    parameter logic [31:0] RESET_VEC = 32'h0000_3000,
    parameter logic [31:0] EXC_VEC   = 32'h0000_4180,
    parameter int          INC       = 4,
    parameter int          RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [2:0]       sel,
    input  logic             br_taken,
    input  logic [15:0]      imm16,
    input  logic [25:0]      jidx,
    input  logic [WIDTH-1:0] rs_val,
    input  logic             exc,
    input  logic             eret,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] epc,
    output logic [1:0]       exc_cause,
    output logic             in_handler
`ifdef PC_GEN_RAS_EN
    ,
    output logic [WIDTH-1:0] ras_top,
    output logic             ras_empty
`endif
);

    localparam logic [WIDTH-1:0] RST_PC = WIDTH'(RESET_VEC);
    localparam logic [WIDTH-1:0] EXC_PC = WIDTH'(EXC_VEC);
    localparam logic [WIDTH-1:0] INC_W  = WIDTH'(INC);
    localparam logic [WIDTH-1:0] LOW28  = WIDTH'(28'hFFF_FFFF);

    localparam logic [2:0] SEL_BR  = 3'd1;
    localparam logic [2:0] SEL_J   = 3'd2;
    localparam logic [2:0] SEL_JR  = 3'd3;
    localparam logic [2:0] SEL_JAL = 3'd4;

    logic [WIDTH-1:0] pc_q, pc_d, epc_q, epc_d;
    logic [1:0]       cause_q, cause_d;
    logic             inh_q, inh_d;
    logic [WIDTH-1:0] br_off, j_tgt, sel_tgt;
    logic             misalign, exc_take, ret_take, accept;

    always_comb begin
        pc_plus4 = pc_q + INC_W;
        br_off   = {{(WIDTH-18){imm16[15]}}, imm16, 2'b00};
        // J/JAL keep the region bits of the sequential PC above bit 27
        j_tgt    = (pc_plus4 & ~LOW28) | WIDTH'({jidx, 2'b00});
        sel_tgt  = pc_plus4;
        case (sel)
            SEL_BR:          if (br_taken) sel_tgt = pc_plus4 + br_off;
            SEL_J, SEL_JAL:  sel_tgt = j_tgt;
            SEL_JR:          sel_tgt = rs_val;
            default:         sel_tgt = pc_plus4;
        endcase

        misalign = (sel == SEL_JR) && (rs_val[1:0] != 2'b00);
        exc_take = exc && !inh_q;
        ret_take = eret && inh_q;
        accept   = !misalign && !exc_take && !stall && !ret_take;

        pc_d    = pc_q;
        epc_d   = epc_q;
        cause_d = cause_q;
        inh_d   = inh_q;
        if (misalign) begin
            // A nested fault keeps the EPC of the original interrupted instruction
            pc_d    = EXC_PC;
            cause_d = 2'd2;
            inh_d   = 1'b1;
            if (!inh_q) epc_d = pc_q;
        end else if (exc_take) begin
            pc_d    = EXC_PC;
            epc_d   = pc_q;
            cause_d = 2'd1;
            inh_d   = 1'b1;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (ret_take) begin
            pc_d    = epc_q;
            cause_d = 2'd0;
            inh_d   = 1'b0;
        end else begin
            pc_d = sel_tgt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RST_PC;
            epc_q   <= '0;
            cause_q <= 2'd0;
            inh_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
            inh_q   <= inh_d;
        end
    end

    assign pc         = pc_q;
    assign epc        = epc_q;
    assign exc_cause  = cause_q;
    assign in_handler = inh_q;

`ifdef PC_GEN_RAS_EN
    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [WIDTH-1:0] ras_mem_q [RAS_DEPTH];
    logic [WIDTH-1:0] ras_mem_d [RAS_DEPTH];
    logic [PW-1:0]    ras_ptr_q, ras_ptr_d, ras_ptr_inc, ras_ptr_dec;
    logic [CW-1:0]    ras_cnt_q, ras_cnt_d;
    logic             ras_push, ras_pop;

    always_comb begin
        ras_empty   = (ras_cnt_q == '0);
        ras_top     = ras_empty ? '0 : ras_mem_q[ras_ptr_q];
        ras_ptr_inc = (ras_ptr_q == PW'(RAS_DEPTH - 1)) ? '0 : ras_ptr_q + 1'b1;
        ras_ptr_dec = (ras_ptr_q == '0) ? PW'(RAS_DEPTH - 1) : ras_ptr_q - 1'b1;
        ras_push    = accept && !inh_q && (sel == SEL_JAL);
        ras_pop     = accept && !inh_q && (sel == SEL_JR) && (rs_val == ras_top) && !ras_empty;

        ras_mem_d = ras_mem_q;
        ras_ptr_d = ras_ptr_q;
        ras_cnt_d = ras_cnt_q;
        if (ras_push) begin
            // Circular: when full the new entry overwrites the oldest
            ras_ptr_d            = ras_ptr_inc;
            ras_mem_d[ras_ptr_inc] = pc_plus4;
            if (ras_cnt_q != CW'(RAS_DEPTH)) ras_cnt_d = ras_cnt_q + 1'b1;
        end else if (ras_pop) begin
            ras_ptr_d = ras_ptr_dec;
            ras_cnt_d = ras_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RAS_DEPTH; i++) ras_mem_q[i] <= '0;
            ras_ptr_q <= '0;
            ras_cnt_q <= '0;
        end else begin
            ras_mem_q <= ras_mem_d;
            ras_ptr_q <= ras_ptr_d;
            ras_cnt_q <= ras_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: expectations queued at drive time, popped and checked after each edge.
module tb_pc_gen;
    logic        clk = 1'b0;
    logic        rst, stall, br_taken, exc, eret;
    logic [2:0]  sel;
    logic [15:0] imm16;
    logic [25:0] jidx;
    logic [31:0] rs_val;
    logic [31:0] pc, pc_plus4, epc;
    logic [1:0]  exc_cause;
    logic        in_handler;
`ifdef PC_GEN_RAS_EN
    logic [31:0] ras_top;
    logic        ras_empty;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] epc;
        logic [1:0]  cause;
        logic        inh;
        string       tag;
    } exp_t;
    exp_t sb[$];

    pc_gen dut (
        .clk(clk), .rst(rst), .stall(stall), .sel(sel), .br_taken(br_taken),
        .imm16(imm16), .jidx(jidx), .rs_val(rs_val), .exc(exc), .eret(eret),
        .pc(pc), .pc_plus4(pc_plus4), .epc(epc), .exc_cause(exc_cause),
        .in_handler(in_handler)
`ifdef PC_GEN_RAS_EN
        , .ras_top(ras_top), .ras_empty(ras_empty)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, want);
        end
    endtask

    // Drive one cycle of inputs, queue what pc_gen must show after the edge, then check it.
    task automatic step(input logic [2:0] s, input logic bt, input logic [15:0] im,
                        input logic [25:0] ji, input logic [31:0] rv,
                        input logic st, input logic ex, input logic er, input logic r,
                        input logic [31:0] e_pc, input logic [31:0] e_epc,
                        input logic [1:0] e_cause, input logic e_inh, input string tag);
        exp_t e;
        sel = s; br_taken = bt; imm16 = im; jidx = ji; rs_val = rv;
        stall = st; exc = ex; eret = er; rst = r;
        e.pc = e_pc; e.epc = e_epc; e.cause = e_cause; e.inh = e_inh; e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.tag, ".pc"}, pc, e.pc);
        chk({e.tag, ".pc_plus4"}, pc_plus4, e.pc + 32'd4);
        chk({e.tag, ".epc"}, epc, e.epc);
        chk({e.tag, ".cause"}, {30'd0, exc_cause}, {30'd0, e.cause});
        chk({e.tag, ".inh"}, {31'd0, in_handler}, {31'd0, e.inh});
    endtask

    initial begin
        sel = 3'd0; br_taken = 0; imm16 = 0; jidx = 0; rs_val = 0;
        stall = 0; exc = 0; eret = 0; rst = 1;
        @(posedge clk); #1;
        //    sel   bt  imm       jidx      rs_val        st ex er rst  pc            epc           c  inh
        step(3'd0, 0, 16'h0,    26'h0,    32'h0,        0, 0, 0, 1, 32'h3000,     32'h0,    2'd0, 0, "reset");
        step(3'd0, 0, 16'h0,    26'h0,    32'h0,        0, 0, 0, 0, 32'h3004,     32'h0,    2'd0, 0, "seq1");
        step(3'd0, 0, 16'h0,    26'h0,    32'h0,        0, 0, 0, 0, 32'h3008,     32'h0,    2'd0, 0, "seq2");
        step(3'd0, 0, 16'h0,    26'h0,    32'h0,        0, 0, 0, 0, 32'h300C,     32'h0,    2'd0, 0, "seq3");
        step(3'd7, 0, 16'h0,    26'h0,    32'h0,        0, 0, 0, 0, 32'h3010,     32'h0,    2'd0, 0, "sel7_seq");
        step(3'd1, 1, 16'hFFFE, 26'h0,    32'h0,        0, 0, 0, 0, 32'h300C,     32'h0,    2'd0, 0, "br_back");
        step(3'd3, 0, 16'h0,    26'h0,    32'h3010,     0, 0, 0, 0, 32'h3010,     32'h0,    2'd0, 0, "jr_3010");
        step(3'd1, 0, 16'hFFFE, 26'h0,    32'h0,        0, 0, 0, 0, 32'h3014,     32'h0,    2'd0, 0, "br_nt");
        step(3'd0, 0, 16'h0,    26'h0,    32'h0,        0, 0, 0, 1, 32'h3000,     32'h0,    2'd0, 0, "reset2");
        step(3'd2, 0, 16'h0,    26'h100,  32'h0,        0, 0, 0, 0, 32'h0400,     32'h0,    2'd0, 0, "j_400");
        step(3'd3, 0, 16'h0,    26'h0,    32'h3020,     0, 0, 0, 0, 32'h3020,     32'h0,    2'd0, 0, "jr_3020");
        step(3'd3, 0, 16'h0,    26'h0,    32'h3022,     0, 0, 0, 0, 32'h4180,     32'h3020, 2'd2, 1, "jr_misal");
        step(3'd0, 0, 16'h0,    26'h0,    32'h0,        0, 0, 1, 0, 32'h3020,     32'h3020, 2'd0, 0, "eret");
        step(3'd0, 0, 16'h0,    26'h0,    32'h0,        0, 0, 1, 0, 32'h3024,     32'h3020, 2'd0, 0, "eret_idle");
        step(3'd0, 0, 16'h0,    26'h0,    32'h0,        0, 0, 0, 1, 32'h3000,     32'h0,    2'd0, 0, "reset3");
        step(3'd0, 0, 16'h0,    26'h0,    32'h0,        0, 0, 0, 0, 32'h3004,     32'h0,    2'd0, 0, "seq4");
        step(3'd0, 0, 16'h0,    26'h0,    32'h0,        0, 0, 0, 0, 32'h3008,     32'h0,    2'd0, 0, "seq5");
        step(3'd0, 0, 16'h0,    26'h0,    32'h0,        1, 0, 0, 0, 32'h3008,     32'h0,    2'd0, 0, "stall1");
        step(3'd2, 0, 16'h0,    26'h55,   32'h0,        1, 0, 0, 0, 32'h3008,     32'h0,    2'd0, 0, "stall2");
        step(3'd0, 0, 16'h0,    26'h0,    32'h0,        1, 1, 0, 0, 32'h4180,     32'h3008, 2'd1, 1, "exc_stall");
        step(3'd0, 0, 16'h0,    26'h0,    32'h0,        0, 0, 0, 0, 32'h4184,     32'h3008, 2'd1, 1, "hdl_seq");
        step(3'd0, 0, 16'h0,    26'h0,    32'h0,        0, 1, 0, 0, 32'h4188,     32'h3008, 2'd1, 1, "exc_masked");
        step(3'd0, 0, 16'h0,    26'h0,    32'h0,        1, 0, 1, 0, 32'h4188,     32'h3008, 2'd1, 1, "eret_stall");
        step(3'd0, 0, 16'h0,    26'h0,    32'h0,        0, 1, 1, 0, 32'h3008,     32'h3008, 2'd0, 0, "exc_eret");
        step(3'd0, 0, 16'h0,    26'h0,    32'h0,        0, 1, 0, 0, 32'h4180,     32'h3008, 2'd1, 1, "exc_again");
        step(3'd0, 0, 16'h0,    26'h0,    32'h0,        1, 0, 0, 1, 32'h3000,     32'h0,    2'd0, 0, "rst_in_hdl");
        step(3'd3, 0, 16'h0,    26'h0,    32'h3001,     1, 0, 0, 0, 32'h4180,     32'h3000, 2'd2, 1, "misal_stall");
        step(3'd3, 0, 16'h0,    26'h0,    32'h0005,     0, 0, 0, 0, 32'h4180,     32'h3000, 2'd2, 1, "misal_nest");
        step(3'd0, 0, 16'h0,    26'h0,    32'h0,        0, 0, 1, 0, 32'h3000,     32'h3000, 2'd0, 0, "eret2");
        step(3'd3, 0, 16'h0,    26'h0,    32'hFFFFFFFC, 0, 0, 0, 0, 32'hFFFFFFFC, 32'h3000, 2'd0, 0, "jr_top");
        step(3'd0, 0, 16'h0,    26'h0,    32'h0,        0, 0, 0, 0, 32'h0,        32'h3000, 2'd0, 0, "wrap");
        step(3'd1, 1, 16'h0001, 26'h0,    32'h0,        0, 0, 0, 0, 32'h8,        32'h3000, 2'd0, 0, "br_fwd");
        step(3'd3, 0, 16'h0,    26'h0,    32'hF0000010, 0, 0, 0, 0, 32'hF0000010, 32'h3000, 2'd0, 0, "jr_hi");
        step(3'd2, 0, 16'h0,    26'h1,    32'h0,        0, 0, 0, 0, 32'hF0000004, 32'h3000, 2'd0, 0, "j_region");
        step(3'd0, 0, 16'h0,    26'h0,    32'h0,        0, 0, 0, 1, 32'h3000,     32'h0,    2'd0, 0, "reset4");
`ifdef PC_GEN_RAS_EN
        chk("ras_empty_rst", {31'd0, ras_empty}, 32'd1);
        chk("ras_top_rst", ras_top, 32'h0);
        step(3'd4, 0, 16'h0,    26'hC40,  32'h0,        0, 0, 0, 0, 32'h3100,     32'h0,    2'd0, 0, "jal1");
        chk("ras_top_jal1", ras_top, 32'h3004);
        step(3'd4, 0, 16'h0,    26'hC80,  32'h0,        0, 0, 0, 0, 32'h3200,     32'h0,    2'd0, 0, "jal2");
        step(3'd4, 0, 16'h0,    26'hCC0,  32'h0,        0, 0, 0, 0, 32'h3300,     32'h0,    2'd0, 0, "jal3");
        step(3'd4, 0, 16'h0,    26'hD00,  32'h0,        0, 0, 0, 0, 32'h3400,     32'h0,    2'd0, 0, "jal4");
        step(3'd4, 0, 16'h0,    26'h100,  32'h0,        0, 0, 0, 0, 32'h0400,     32'h0,    2'd0, 0, "jal5");
        chk("ras_top_jal5", ras_top, 32'h3404);
        step(3'd3, 0, 16'h0,    26'h0,    32'h3404,     0, 0, 0, 0, 32'h3404,     32'h0,    2'd0, 0, "pop1");
        chk("ras_top_pop1", ras_top, 32'h3304);
        step(3'd3, 0, 16'h0,    26'h0,    32'h3304,     0, 0, 0, 0, 32'h3304,     32'h0,    2'd0, 0, "pop2");
        step(3'd3, 0, 16'h0,    26'h0,    32'h3204,     0, 0, 0, 0, 32'h3204,     32'h0,    2'd0, 0, "pop3");
        chk("ras_top_pop3", ras_top, 32'h3104);
        chk("ras_nonempty", {31'd0, ras_empty}, 32'd0);
        step(3'd3, 0, 16'h0,    26'h0,    32'h3104,     0, 0, 0, 0, 32'h3104,     32'h0,    2'd0, 0, "pop4");
        chk("ras_empty_pop4", {31'd0, ras_empty}, 32'd1);
        step(3'd3, 0, 16'h0,    26'h0,    32'h3000,     0, 0, 0, 0, 32'h3000,     32'h0,    2'd0, 0, "pop_empty");
        chk("ras_empty_still", {31'd0, ras_empty}, 32'd1);
        chk("ras_top_empty", ras_top, 32'h0);
`endif
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
